// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the command-driven interval counter: command opcodes,
// controller states and run modes.
package counter_ctrl_pkg;

  localparam logic [1:0] OP_NOP      = 2'b00;
  localparam logic [1:0] OP_ONESHOT  = 2'b01;
  localparam logic [1:0] OP_PERIODIC = 2'b10;
  localparam logic [1:0] OP_STOP     = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_t;

endpackage

// File: rtl/counter_prescale.sv
// Programmable clock divider: one tick every (div_i + 1) enabled cycles.
module counter_prescale #(
  parameter int PRE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [PRE_W-1:0] div_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  // Clear wins over a coincident tick so a restart always begins a full interval.
  always_comb begin
    tick_o = en_i && (cnt_q == div_i);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven interval counter: START/STOP over valid/ready, prescaled
// ticks, one-shot or periodic terminal count with a one-cycle done pulse.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int PRE_W = 8,
  parameter int PER_W = 8
) (
  input  logic             clk_100m,
  input  logic             reset,
  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready depends on state only and drops for the single LOAD cycle.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_limit,
  input  logic [PRE_W-1:0] cmd_prescale,
  input  logic             pause,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [PER_W-1:0] period_cnt,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d, lim_q, lim_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             done_q, done_d, busy_q;
  logic             accept, tick, pre_clr, pre_en;

  assign cmd_ready = (state_q != S_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  // PAUSE with pause released already counts, so a pause costs exactly its length.
  assign pre_en    = ((state_q == S_RUN) || (state_q == S_PAUSE)) && !pause;

  counter_prescale #(.PRE_W(PRE_W)) u_prescale (
    .clk_i  (clk_100m),
    .rst_i  (reset),
    .clr_i  (pre_clr),
    .en_i   (pre_en),
    .div_i  (pre_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    lim_d    = lim_q;
    pre_d    = pre_q;
    period_d = period_q;
    done_d   = 1'b0;
    pre_clr  = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        count_d  = '0;
        period_d = '0;
        pre_clr  = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN, S_PAUSE: begin
        state_d = pause ? S_PAUSE : S_RUN;
        if (tick) begin
          if (count_q == lim_q) begin
            done_d = 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              state_d = S_IDLE;
            end else begin
              count_d = '0;
              if (period_q != '1) period_d = period_q + PER_W'(1);
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    // An accepted command overrides whatever the terminal tick decided above.
    if (accept) begin
      case (cmd_op)
        OP_ONESHOT, OP_PERIODIC: begin
          state_d  = S_LOAD;
          mode_d   = (cmd_op == OP_PERIODIC) ? MODE_PERIODIC : MODE_ONESHOT;
          lim_d    = cmd_limit;
          pre_d    = cmd_prescale;
          count_d  = '0;
          period_d = '0;
          done_d   = 1'b0;
          pre_clr  = 1'b1;
        end
        OP_STOP: begin
          if (state_q != S_IDLE) begin
            state_d  = S_IDLE;
            count_d  = count_q;
            period_d = period_q;
            done_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100m) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_ONESHOT;
      count_q  <= '0;
      lim_q    <= '0;
      pre_q    <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      lim_q    <= lim_d;
      pre_q    <= pre_d;
      period_q <= period_d;
      done_q   <= done_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign count      = count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign period_cnt = period_q;
  assign dbg_state  = state_q;

endmodule
